// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

    // Reader FSM: wait for a full burst, then drain it.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Beat counter must be able to hold values 0 .. burst_len.
    function automatic int beat_cnt_width(input int burst_len);
        return (burst_len < 1) ? 1 : $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// Registered valid/ready output stage: load a new word, clear valid once
// it has been accepted, otherwise hold everything stable.
module stream_out_reg #(
    parameter int DWIDTH = 4
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_sop,
    input  logic              i_eop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_valid,
    output logic              o_sop,
    output logic              o_eop
);

    logic [DWIDTH-1:0] r_data;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;

    // Output register: load has priority over clear; otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length bursts from a show-ahead FIFO onto a registered
// valid/ready stream with start/end-of-packet markers.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DWIDTH    = 4,
    parameter int AWIDTH    = 7,
    parameter int BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o,
    output logic              busy_o
);

    localparam int              BW             = beat_cnt_width(BURST_LEN);
    localparam logic [AWIDTH:0] LP_BURST_USEDW = (AWIDTH+1)'(BURST_LEN);
    localparam logic [BW-1:0]   LP_LAST_BEAT   = BW'(BURST_LEN - 1);

    state_t        r_state;
    logic [BW-1:0] r_beat;

    logic w_pop;
    logic w_first;
    logic w_last;

    // Pop only inside a burst, with data present and room in the output stage.
    always_comb begin
        w_pop   = (r_state == ST_BURST) && !fifo_empty_i && (!valid_o || ready_i) && !srst_i;
        w_first = (r_beat == '0);
        w_last  = (r_beat == LP_LAST_BEAT);
    end

    assign fifo_rdreq_o = w_pop;
    assign busy_o       = (r_state == ST_BURST);

    // FSM and beat counter; occupancy is only looked at while idle.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fifo_usedw_i >= LP_BURST_USEDW) begin
                        r_state <= ST_BURST;
                        r_beat  <= '0;
                    end
                end
                ST_BURST: begin
                    if (w_pop) begin
                        r_beat <= r_beat + BW'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    stream_out_reg #(
        .DWIDTH(DWIDTH)
    ) u_out (
        .i_clk   (clk_i),
        .i_srst  (srst_i),
        .i_load  (w_pop),
        .i_clear (ready_i),
        .i_data  (fifo_q_i),
        .i_sop   (w_first),
        .i_eop   (w_last),
        .o_data  (data_o),
        .o_valid (valid_o),
        .o_sop   (sop_o),
        .o_eop   (eop_o)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench: one reader with 4-word bursts, one with 1-word bursts,
// each fed by a behavioural show-ahead FIFO.
module tb_fifo_burst_reader;

    localparam int DW = 4;
    localparam int AW = 7;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } exp_t;

    logic clk = 1'b0;
    logic srst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Cycle counter for pop spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: BURST_LEN = 4 ----------------
    logic [DW-1:0] memA [0:255];
    int            rdA = 0, wrA = 0, popsA = 0;
    int            popcA [0:255];
    logic          forceA;
    logic [DW-1:0] qA, dataA;
    logic          emptyA, rdreqA, validA, readyA, sopA, eopA, busyA;
    logic [AW:0]   usedwA;
    exp_t          sbA [$];
    exp_t          eA;
    int            eopsA = 0, stallsA = 0, unexpA = 0;
    logic          prev_stallA = 1'b0;
    logic [DW-1:0] prev_dataA;
    logic          prev_sopA, prev_eopA;

    assign usedwA = (AW+1)'(wrA - rdA);
    assign emptyA = (wrA == rdA) || forceA;
    assign qA     = memA[rdA];

    fifo_burst_reader #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .BURST_LEN(4)
    ) dut_a (
        .clk_i       (clk),
        .srst_i      (srst),
        .fifo_q_i    (qA),
        .fifo_empty_i(emptyA),
        .fifo_usedw_i(usedwA),
        .fifo_rdreq_o(rdreqA),
        .data_o      (dataA),
        .valid_o     (validA),
        .ready_i     (readyA),
        .sop_o       (sopA),
        .eop_o       (eopA),
        .busy_o      (busyA)
    );

    // FIFO A read side.
    always @(posedge clk) begin
        if (rdreqA) begin
            rdA          <= rdA + 1;
            popcA[popsA] <= cyc;
            popsA        <= popsA + 1;
        end
    end

    // Monitor A: protocol rules and scoreboard on each handshake.
    always @(negedge clk) begin
        if (srst)    chk("A_rd_in_reset", 32'(rdreqA), 0);
        if (emptyA)  chk("A_rd_when_empty", 32'(rdreqA), 0);
        if (!busyA)  chk("A_rd_in_idle", 32'(rdreqA), 0);
        if (prev_stallA && !srst) begin
            chk("A_hold_valid", 32'(validA), 1);
            chk("A_hold_data", 32'(dataA), 32'(prev_dataA));
            chk("A_hold_sop", 32'(sopA), 32'(prev_sopA));
            chk("A_hold_eop", 32'(eopA), 32'(prev_eopA));
        end
        if (validA && !readyA) begin
            chk("A_rd_backpressure", 32'(rdreqA), 0);
            stallsA <= stallsA + 1;
        end
        if (validA && readyA) begin
            if (sbA.size() == 0) begin
                unexpA <= unexpA + 1;
            end else begin
                eA = sbA.pop_front();
                chk("A_data", 32'(dataA), 32'(eA.d));
                chk("A_sop", 32'(sopA), 32'(eA.sop));
                chk("A_eop", 32'(eopA), 32'(eA.eop));
            end
            if (eopA) eopsA <= eopsA + 1;
        end
        prev_stallA <= validA && !readyA;
        prev_dataA  <= dataA;
        prev_sopA   <= sopA;
        prev_eopA   <= eopA;
    end

    // ---------------- DUT B: BURST_LEN = 1 ----------------
    logic [DW-1:0] memB [0:255];
    int            rdB = 0, wrB = 0, popsB = 0;
    int            popcB [0:255];
    logic [DW-1:0] qB, dataB;
    logic          emptyB, rdreqB, validB, readyB, sopB, eopB, busyB;
    logic [AW:0]   usedwB;
    exp_t          sbB [$];
    exp_t          eB;
    int            eopsB = 0, unexpB = 0;

    assign usedwB = (AW+1)'(wrB - rdB);
    assign emptyB = (wrB == rdB);
    assign qB     = memB[rdB];

    fifo_burst_reader #(
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .BURST_LEN(1)
    ) dut_b (
        .clk_i       (clk),
        .srst_i      (srst),
        .fifo_q_i    (qB),
        .fifo_empty_i(emptyB),
        .fifo_usedw_i(usedwB),
        .fifo_rdreq_o(rdreqB),
        .data_o      (dataB),
        .valid_o     (validB),
        .ready_i     (readyB),
        .sop_o       (sopB),
        .eop_o       (eopB),
        .busy_o      (busyB)
    );

    always @(posedge clk) begin
        if (rdreqB) begin
            rdB          <= rdB + 1;
            popcB[popsB] <= cyc;
            popsB        <= popsB + 1;
        end
    end

    always @(negedge clk) begin
        if (emptyB) chk("B_rd_when_empty", 32'(rdreqB), 0);
        if (!busyB) chk("B_rd_in_idle", 32'(rdreqB), 0);
        if (validB && readyB) begin
            if (sbB.size() == 0) begin
                unexpB <= unexpB + 1;
            end else begin
                eB = sbB.pop_front();
                chk("B_data", 32'(dataB), 32'(eB.d));
                chk("B_sop", 32'(sopB), 32'(eB.sop));
                chk("B_eop", 32'(eopB), 32'(eB.eop));
            end
            if (eopB) eopsB <= eopsB + 1;
        end
    end

    // ---------------- stimulus ----------------
    logic tog = 1'b0;
    int   togk = 0;

    // Advance one cycle; inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (tog) begin
            readyA = ((togk % 4) == 0) || ((togk % 4) == 3);
            togk++;
        end
    endtask

    task automatic push_a(input int v, input logic s, input logic e, input logic expect_it);
        exp_t x;
        memA[wrA] = DW'(v);
        wrA++;
        if (expect_it) begin
            x.d = DW'(v); x.sop = s; x.eop = e;
            sbA.push_back(x);
        end
    endtask

    task automatic push_b(input int v);
        exp_t x;
        memB[wrB] = DW'(v);
        wrB++;
        x.d = DW'(v); x.sop = 1'b1; x.eop = 1'b1;
        sbB.push_back(x);
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while (sbA.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("A_drain_timeout", 32'(sbA.size()), 0);
    endtask

    task automatic wait_pops_a(input int target, input int budget);
        int n = 0;
        while (popsA < target && n < budget) begin
            tick();
            n++;
        end
        chk("A_pop_wait", 32'(popsA), 32'(target));
    endtask

    int base, e0, p;

    initial begin
        srst   = 1'b1;
        readyA = 1'b1;
        readyB = 1'b1;
        forceA = 1'b0;

        // Reset with 3 words already present: below one burst.
        push_a(1, 1'b1, 1'b0, 1'b1);
        push_a(2, 1'b0, 1'b0, 1'b1);
        push_a(3, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        srst = 1'b0;
        repeat (3) tick();
        chk("rst_rdreq", 32'(rdreqA), 0);
        chk("rst_busy", 32'(busyA), 0);
        chk("rst_data", 32'(dataA), 0);
        chk("rst_valid", 32'(validA), 0);
        chk("rst_sop", 32'(sopA), 0);
        chk("rst_eop", 32'(eopA), 0);
        chk("rst_usedw", 32'(usedwA), 3);

        // Scenario 1: words 1..5, ready high.
        base = popsA; e0 = eopsA;
        push_a(4, 1'b0, 1'b1, 1'b1);
        push_a(5, 1'b0, 1'b0, 1'b0);
        chk("s1_not_started", 32'(busyA), 0);
        tick();
        chk("s1_start_busy", 32'(busyA), 1);
        chk("s1_start_rdreq", 32'(rdreqA), 1);
        drain_a(40);
        repeat (2) tick();
        chk("s1_pops", 32'(popsA - base), 4);
        chk("s1_consecutive", 32'(popcA[base+3] - popcA[base]), 3);
        chk("s1_eops", 32'(eopsA - e0), 1);
        chk("s1_leftover", 32'(usedwA), 1);
        chk("s1_idle_after", 32'(busyA), 0);

        // Scenario 2: leftover 5 plus 6..8, ready pattern 1,0,0,1.
        base = popsA; e0 = eopsA;
        sbA.push_back('{d: DW'(5), sop: 1'b1, eop: 1'b0});
        push_a(6, 1'b0, 1'b0, 1'b1);
        push_a(7, 1'b0, 1'b0, 1'b1);
        push_a(8, 1'b0, 1'b1, 1'b1);
        tog = 1'b1; togk = 0;
        drain_a(80);
        tog = 1'b0; readyA = 1'b1;
        repeat (2) tick();
        chk("s2_pops", 32'(popsA - base), 4);
        chk("s2_eops", 32'(eopsA - e0), 1);
        chk("s2_stalls_seen", 32'(stallsA > 0), 1);
        chk("s2_leftover", 32'(usedwA), 0);

        // Scenario 3: FIFO reads empty for 3 cycles after the second pop.
        base = popsA; e0 = eopsA;
        push_a(9,  1'b1, 1'b0, 1'b1);
        push_a(10, 1'b0, 1'b0, 1'b1);
        push_a(11, 1'b0, 1'b0, 1'b1);
        push_a(12, 1'b0, 1'b1, 1'b1);
        wait_pops_a(base + 2, 40);
        forceA = 1'b1;
        p = popsA;
        repeat (3) tick();
        chk("s3_stalled", 32'(popsA), 32'(p));
        chk("s3_busy_in_stall", 32'(busyA), 1);
        forceA = 1'b0;
        drain_a(40);
        repeat (2) tick();
        chk("s3_pops", 32'(popsA - base), 4);
        chk("s3_eops", 32'(eopsA - e0), 1);

        // Scenario 4: reset after the second pop; remaining 4 form a new burst.
        base = popsA; e0 = eopsA;
        push_a(13, 1'b1, 1'b0, 1'b1);
        push_a(14, 1'b0, 1'b0, 1'b1);
        push_a(15, 1'b1, 1'b0, 1'b1);
        push_a(16, 1'b0, 1'b0, 1'b1);
        push_a(17, 1'b0, 1'b0, 1'b1);
        push_a(18, 1'b0, 1'b1, 1'b1);
        wait_pops_a(base + 2, 40);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("s4_valid_after_rst", 32'(validA), 0);
        chk("s4_busy_after_rst", 32'(busyA), 0);
        chk("s4_eop_after_rst", 32'(eopA), 0);
        drain_a(40);
        repeat (2) tick();
        chk("s4_pops", 32'(popsA - base), 6);
        chk("s4_eops", 32'(eopsA - e0), 1);
        chk("s4_leftover", 32'(usedwA), 0);
        chk("A_unexpected_words", 32'(unexpA), 0);

        // BURST_LEN=1: three single-word bursts with one-cycle gaps.
        push_b(4'hA);
        push_b(4'hB);
        push_b(4'hC);
        begin : drain_b
            int n = 0;
            while (sbB.size() != 0 && n < 40) begin
                tick();
                n++;
            end
            chk("B_drain_timeout", 32'(sbB.size()), 0);
        end
        repeat (2) tick();
        chk("B_pops", 32'(popsB), 3);
        chk("B_gap01", 32'(popcB[1] - popcB[0]), 2);
        chk("B_gap12", 32'(popcB[2] - popcB[1]), 2);
        chk("B_eops", 32'(eopsB), 3);
        chk("B_idle_after", 32'(busyB), 0);
        chk("B_unexpected_words", 32'(unexpB), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
